// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: FSM states, settle-counter
// width and two-input truth-table constants (bit v = gate output for input v).
package gate_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } gsc_state_e;

  localparam int unsigned SETTLE_W = 4;

  localparam logic [3:0] EXP2_AND  = 4'b1000;
  localparam logic [3:0] EXP2_OR   = 4'b1110;
  localparam logic [3:0] EXP2_NAND = 4'b0111;
  localparam logic [3:0] EXP2_NOR  = 4'b0001;
  localparam logic [3:0] EXP2_XOR  = 4'b0110;

endpackage

// File: rtl/gate_sweep_checker_settle.sv
// settle_timer: loadable down-counter that stops at zero; zero flags expiry
// of the hold window for the current vector.
module settle_timer
  import gate_sweep_checker_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] val,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input vector of a small gate in order,
// samples its output and records mismatches. Optional GATE_CHK_MISMATCH_MAP_EN.
module gate_sweep_checker
  import gate_sweep_checker_pkg::*;
#(
  parameter int          N_IN          = 2,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECT        = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   drive,
  input  logic              gate_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   fail_vec
`ifdef GATE_CHK_MISMATCH_MAP_EN
  ,
  output logic [(2**N_IN)-1:0] mismatch_map
`endif
);

  localparam int unsigned       NV       = 2 ** N_IN;
  localparam logic [NV-1:0]     EXP_TBL  = EXPECT[NV-1:0];
  localparam logic [N_IN-1:0]   LAST_IDX = '1;
  localparam logic [SETTLE_W-1:0] SETTLE = SETTLE_W'(SETTLE_CYCLES);

  gsc_state_e state, state_nxt;

  logic [N_IN-1:0] idx;
  logic            accept;
  logic            sample;
  logic            last_vec;
  logic            mismatch;
  logic [N_IN:0]   err_nxt;
  logic            timer_load;
  logic            timer_zero;

  settle_timer u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .val   (SETTLE),
    .zero  (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    sample     = 1'b0;
    timer_load = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        if (last_vec) begin
          state_nxt = ST_DONE;
        end else begin
          timer_load = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign last_vec = (idx == LAST_IDX);
  assign mismatch = (gate_out != EXP_TBL[idx]);
  assign err_nxt  = err_count + (N_IN+1)'(mismatch);
  assign drive    = idx;

  // fail_vec latches on the first mismatch: err_count is still zero at that edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        idx       <= '0;
        busy      <= 1'b1;
        pass      <= 1'b0;
        err_count <= '0;
        fail_vec  <= '0;
      end else if (sample) begin
        err_count <= err_nxt;
        if (mismatch && (err_count == '0)) begin
          fail_vec <= idx;
        end
        if (last_vec) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

`ifdef GATE_CHK_MISMATCH_MAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_map <= '0;
    end else if (accept) begin
      mismatch_map <= '0;
    end else if (sample && mismatch) begin
      mismatch_map[idx] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three configurations, table vectors, corner
// sequences and random sweeps against a truth-table reference model.
module tb_gate_sweep_checker;
  import gate_sweep_checker_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start_v;
  logic [15:0] gut [3];

  int checks = 0;
  int errors = 0;

  int          p_n [3] = '{2, 1, 3};
  int          p_s [3] = '{1, 0, 2};
  logic [15:0] p_exp [3] = '{16'h0001, 16'h0001, 16'h0096};

  always #5 clk = ~clk;

  // instance A: N_IN=2, S=1, NOR table
  logic [1:0] drive_a, fail_a;
  logic       gate_a, busy_a, done_a, pass_a;
  logic [2:0] err_a;
  // instance B: N_IN=1, S=0, inverter table
  logic [0:0] drive_b, fail_b;
  logic       gate_b, busy_b, done_b, pass_b;
  logic [1:0] err_b;
  // instance C: N_IN=3, S=2, 3-input XOR table
  logic [2:0] drive_c, fail_c;
  logic       gate_c, busy_c, done_c, pass_c;
  logic [3:0] err_c;

  assign gate_a = gut[0][{2'b00, drive_a}];
  assign gate_b = gut[1][{3'b000, drive_b}];
  assign gate_c = gut[2][{1'b0, drive_c}];

  int          obs_drive [3], obs_busy [3], obs_done [3], obs_pass [3];
  int          obs_err [3], obs_fail [3], obs_map [3];

`ifdef GATE_CHK_MISMATCH_MAP_EN
  logic [3:0] map_a;
  logic [1:0] map_b;
  logic [7:0] map_c;
  assign obs_map[0] = int'(map_a);
  assign obs_map[1] = int'(map_b);
  assign obs_map[2] = int'(map_c);
`else
  assign obs_map[0] = 0;
  assign obs_map[1] = 0;
  assign obs_map[2] = 0;
`endif

  gate_sweep_checker #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECT(16'(EXP2_NOR))) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .drive(drive_a), .gate_out(gate_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fail_a)
`ifdef GATE_CHK_MISMATCH_MAP_EN
    , .mismatch_map(map_a)
`endif
  );

  gate_sweep_checker #(.N_IN(1), .SETTLE_CYCLES(0), .EXPECT(16'h0001)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .drive(drive_b), .gate_out(gate_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fail_b)
`ifdef GATE_CHK_MISMATCH_MAP_EN
    , .mismatch_map(map_b)
`endif
  );

  gate_sweep_checker #(.N_IN(3), .SETTLE_CYCLES(2), .EXPECT(16'h0096)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .drive(drive_c), .gate_out(gate_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .fail_vec(fail_c)
`ifdef GATE_CHK_MISMATCH_MAP_EN
    , .mismatch_map(map_c)
`endif
  );

  assign obs_drive[0] = int'(drive_a); assign obs_drive[1] = int'(drive_b); assign obs_drive[2] = int'(drive_c);
  assign obs_busy[0]  = int'(busy_a);  assign obs_busy[1]  = int'(busy_b);  assign obs_busy[2]  = int'(busy_c);
  assign obs_done[0]  = int'(done_a);  assign obs_done[1]  = int'(done_b);  assign obs_done[2]  = int'(done_c);
  assign obs_pass[0]  = int'(pass_a);  assign obs_pass[1]  = int'(pass_b);  assign obs_pass[2]  = int'(pass_c);
  assign obs_err[0]   = int'(err_a);   assign obs_err[1]   = int'(err_b);   assign obs_err[2]   = int'(err_c);
  assign obs_fail[0]  = int'(fail_a);  assign obs_fail[1]  = int'(fail_b);  assign obs_fail[2]  = int'(fail_c);

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Results after the first `sampled` vectors have been compared.
  task automatic model(input int i, input logic [15:0] tt, input int sampled,
                       output int e_err, output int e_fail, output int e_map);
    e_err = 0; e_fail = 0; e_map = 0;
    for (int v = 0; v < sampled; v++) begin
      if (tt[v] != p_exp[i][v]) begin
        if (e_err == 0) e_fail = v;
        e_err++;
        e_map = e_map | (1 << v);
      end
    end
  endtask

  task automatic check_idle_zero(input int i, input string nm);
    check({nm, " drive"}, obs_drive[i], 0);
    check({nm, " busy"},  obs_busy[i], 0);
    check({nm, " done"},  obs_done[i], 0);
    check({nm, " pass"},  obs_pass[i], 0);
    check({nm, " err"},   obs_err[i], 0);
    check({nm, " fail"},  obs_fail[i], 0);
`ifdef GATE_CHK_MISMATCH_MAP_EN
    check({nm, " map"},   obs_map[i], 0);
`endif
  endtask

  // Full sweep, checked every cycle; optional stray start sampled at edge E0+pulse_at.
  task automatic run_sweep(input int i, input logic [15:0] tt, input int pulse_at, input string nm);
    int nv, per, total, q, sampled, e_drive, e_err, e_fail, e_map;
    nv = 1 << p_n[i];
    per = p_s[i] + 2;
    total = nv * per;
    gut[i] = tt;
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    for (int k = 0; k <= total + 2; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      q = k / per;
      sampled = (q < nv) ? q : nv;
      e_drive = (q < nv) ? q : nv - 1;
      model(i, tt, sampled, e_err, e_fail, e_map);
      check({nm, " drive"}, obs_drive[i], e_drive);
      check({nm, " busy"},  obs_busy[i], int'(k < total));
      check({nm, " done"},  obs_done[i], int'(k == total));
      check({nm, " pass"},  obs_pass[i], int'(k >= total && e_err == 0));
      check({nm, " err"},   obs_err[i], e_err);
      check({nm, " fail"},  obs_fail[i], e_fail);
`ifdef GATE_CHK_MISMATCH_MAP_EN
      check({nm, " map"},   obs_map[i], e_map);
`endif
      if (pulse_at > 0 && k == pulse_at - 1) start_v[i] = 1'b1;
      if (pulse_at > 0 && k == pulse_at)     start_v[i] = 1'b0;
    end
  endtask

  task automatic wait_done(input int i, input int budget, input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk);
      #1;
      if (obs_done[i] == 1) seen = 1'b1;
    end
    check({nm, " done within budget"}, int'(seen), 1);
  endtask

  typedef struct {
    int          inst;
    logic [15:0] tt;
    int          pulse;
    int          err;
    int          fail;
    int          pass;
    int          map;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int i, nv, total, pulse;
    logic [15:0] tt;

    tbl[0] = '{0, 16'h0001, 0, 0, 0, 1, 4'b0000}; // NOR gut
    tbl[1] = '{0, 16'h0007, 5, 2, 1, 0, 4'b0110}; // NAND gut, stray start at E0+5
    tbl[2] = '{0, 16'h000F, 0, 3, 1, 0, 4'b1110}; // output stuck at 1
    tbl[3] = '{0, 16'h0008, 0, 2, 0, 0, 4'b1001}; // AND gut
    tbl[4] = '{0, 16'h000E, 0, 4, 0, 0, 4'b1111}; // OR gut: every vector wrong
    tbl[5] = '{0, 16'h0006, 0, 3, 0, 0, 4'b0111}; // XOR gut
    tbl[6] = '{1, 16'h0001, 0, 0, 0, 1, 2'b00};   // inverter
    tbl[7] = '{1, 16'h0002, 0, 2, 0, 0, 2'b11};   // buffer
    tbl[8] = '{2, 16'h0096, 0, 0, 0, 1, 8'h00};   // 3-input XOR
    tbl[9] = '{2, 16'h0000, 3, 4, 1, 0, 8'h96};   // stuck at 0

    rst_n = 1'b0;
    start_v = '0;
    gut[0] = '0; gut[1] = '0; gut[2] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero(0, "reset A");
    check_idle_zero(1, "reset B");
    check_idle_zero(2, "reset C");
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 10; t++) begin
      run_sweep(tbl[t].inst, tbl[t].tt, tbl[t].pulse, $sformatf("vec%0d", t));
      check($sformatf("vec%0d final err", t),  obs_err[tbl[t].inst],  tbl[t].err);
      check($sformatf("vec%0d final fail", t), obs_fail[tbl[t].inst], tbl[t].fail);
      check($sformatf("vec%0d final pass", t), obs_pass[tbl[t].inst], tbl[t].pass);
`ifdef GATE_CHK_MISMATCH_MAP_EN
      check($sformatf("vec%0d final map", t),  obs_map[tbl[t].inst],  tbl[t].map);
`endif
    end

    // Reset in the middle of a sweep discards everything.
    gut[0] = 16'h000F;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midreset busy before", obs_busy[0], 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_idle_zero(0, "midreset");
    rst_n = 1'b1;
    run_sweep(0, 16'h0001, 0, "after reset");

    // start held high: the next sweep is accepted the first edge the FSM is idle.
    gut[0] = 16'h0001;
    @(negedge clk);
    start_v[0] = 1'b1;
    wait_done(0, 40, "held start first");
    @(posedge clk);
    #1;
    check("held start idle gap busy", obs_busy[0], 0);
    check("held start idle gap pass", obs_pass[0], 1);
    @(posedge clk);
    #1;
    check("held start reaccept busy", obs_busy[0], 1);
    check("held start reaccept pass", obs_pass[0], 0);
    check("held start reaccept drive", obs_drive[0], 0);
    start_v[0] = 1'b0;
    wait_done(0, 40, "held start second");
    @(posedge clk);
    #1;
    check("held start one done", obs_done[0], 0);

    for (int r = 0; r < 24; r++) begin
      i = int'($urandom_range(0, 2));
      nv = 1 << p_n[i];
      total = nv * (p_s[i] + 2);
      tt = 16'($urandom);
      pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, total + 1)) : 0;
      run_sweep(i, tt, pulse, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
